// File: rtl/alu_sequencer.sv
// alu_sequencer: control-side driver for the logic_unit datapath.
// Accepts one operation over a valid/ready request, drives the operands onto
// bus1/bus2, holds exactly one operation strobe for SETTLE cycles, captures
// bus3 and returns it over a valid/ready response.
module alu_sequencer #(
    parameter int WIDTH  = 16,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_err,
    output logic             resp_zero,
    output logic             passthrough,
    output logic             add,
    output logic             sub,
    output logic             shr,
    output logic             shl,
    output logic             band,
    output logic             bor,
    output logic             bxor,
    output logic             bnegate,
    output logic [WIDTH-1:0] bus1,
    output logic [WIDTH-1:0] bus2,
    input  logic [WIDTH-1:0] bus3
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    // The counter is loaded with SETTLE-1 so the strobe spans exactly SETTLE cycles.
    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

    state_t           state_q;
    logic [3:0]       cnt_q;
    logic [8:0]       strobe_q;
    logic [8:0]       strobe_d;
    logic             op_legal;
    logic [WIDTH-1:0] bus1_q;
    logic [WIDTH-1:0] bus2_q;
    logic [WIDTH-1:0] result_q;
    logic             err_q;
    logic             zero_q;
    logic             accept;

    // Handshake status is decoded straight from the state; req_ready is
    // additionally forced low while reset is held.
    assign req_ready  = rst_n && (state_q == IDLE);
    assign resp_valid = (state_q == DONE);
    assign accept     = req_valid && req_ready;

    assign resp_result = result_q;
    assign resp_err    = err_q;
    assign resp_zero   = zero_q;
    assign bus1        = bus1_q;
    assign bus2        = bus2_q;

    // Strobe vector bit order matches the opcode numbering (bit n = opcode n).
    assign passthrough = strobe_q[0];
    assign add         = strobe_q[1];
    assign sub         = strobe_q[2];
    assign shr         = strobe_q[3];
    assign shl         = strobe_q[4];
    assign band        = strobe_q[5];
    assign bor         = strobe_q[6];
    assign bxor        = strobe_q[7];
    assign bnegate     = strobe_q[8];

    // Decode the incoming opcode into a one-hot strobe; illegal opcodes decode to none.
    always_comb begin
        strobe_d = 9'd0;
        op_legal = (req_op <= 4'd8);
        if (op_legal) begin
            strobe_d = 9'd1 << req_op;
        end
    end

    // Sequencer FSM with all outputs registered so the strobes are glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            strobe_q <= 9'd0;
            bus1_q   <= '0;
            bus2_q   <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        bus1_q <= req_a;
                        bus2_q <= req_b;
                        if (op_legal) begin
                            strobe_q <= strobe_d;
                            cnt_q    <= SETTLE_M1;
                            state_q  <= EXEC;
                        end else begin
                            result_q <= '0;
                            zero_q   <= 1'b1;
                            err_q    <= 1'b1;
                            state_q  <= DONE;
                        end
                    end
                end
                EXEC: begin
                    if (cnt_q == 4'd0) begin
                        result_q <= bus3;
                        zero_q   <= (bus3 == '0);
                        err_q    <= 1'b0;
                        strobe_q <= 9'd0;
                        state_q  <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        err_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    strobe_q <= 9'd0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed table, hand-written
// multi-cycle corner cases and randomized transactions checked against a
// transaction-level reference model.
module tb_alu_sequencer;

    localparam int WIDTH  = 16;
    localparam int SETTLE = 2;

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_result;
    logic             resp_err;
    logic             resp_zero;
    logic             passthrough, add, sub, shr, shl, band, bor, bxor, bnegate;
    logic [WIDTH-1:0] bus1;
    logic [WIDTH-1:0] bus2;
    logic [WIDTH-1:0] bus3;
    logic [8:0]       strobeVec;

    int checks = 0;
    int errors = 0;

    alu_sequencer #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_err(resp_err), .resp_zero(resp_zero),
        .passthrough(passthrough), .add(add), .sub(sub), .shr(shr), .shl(shl),
        .band(band), .bor(bor), .bxor(bxor), .bnegate(bnegate),
        .bus1(bus1), .bus2(bus2), .bus3(bus3)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign strobeVec = {bnegate, bxor, bor, band, shl, shr, sub, add, passthrough};

    // Emulated logic_unit: reacts to whichever strobe is high; idles at a marker value
    always_comb begin
        bus3 = 16'hDEAD;
        if (passthrough) bus3 = bus1;
        if (add)         bus3 = bus1 + bus2;
        if (sub)         bus3 = bus1 - bus2;
        if (shr)         bus3 = bus1 >> 1;
        if (shl)         bus3 = bus1 << 1;
        if (band)        bus3 = bus1 & bus2;
        if (bor)         bus3 = bus1 | bus2;
        if (bxor)        bus3 = bus1 ^ bus2;
        if (bnegate)     bus3 = 16'd0 - bus1;
    end

    // Transaction-level reference: what the response should carry for a request
    function automatic logic [WIDTH-1:0] refResult(input logic [3:0] op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        case (op)
            4'd0: return a;
            4'd1: return a + b;
            4'd2: return a - b;
            4'd3: return a >> 1;
            4'd4: return a << 1;
            4'd5: return a & b;
            4'd6: return a | b;
            4'd7: return a ^ b;
            4'd8: return 16'd0 - a;
            default: return 16'd0;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // At most one strobe in any cycle out of reset
    always @(negedge clk) begin
        if (rst_n) checkOutput("strobe_onehot0", {31'd0, $onehot0(strobeVec)}, 32'd1);
    end

    // Issue one request and follow it cycle by cycle until the response handshake.
    // Must be entered at a negedge; returns at a negedge.
    task automatic applyStimulus(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input int respDelay,
                                 input logic [WIDTH-1:0] expRes, input logic expErr);
        logic       legal;
        logic [8:0] expStrobe;
        int         lat;
        bit         got;
        legal     = (op <= 4'd8);
        expStrobe = legal ? (9'd1 << op) : 9'd0;
        lat       = legal ? SETTLE + 1 : 1;
        got       = 1'b0;
        for (int w = 0; w < 20; w++) begin
            if (req_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            checkOutput("req_ready_timeout", 32'd0, 32'd1);
            return;
        end
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 4'($urandom);
        req_a     = 16'($urandom);
        req_b     = 16'($urandom);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            checkOutput("strobes", {23'd0, strobeVec}, (legal && k <= SETTLE) ? {23'd0, expStrobe} : 32'd0);
            checkOutput("resp_valid_timing", {31'd0, resp_valid}, (k == lat) ? 32'd1 : 32'd0);
            checkOutput("req_ready_busy", {31'd0, req_ready}, 32'd0);
            checkOutput("bus1", {16'd0, bus1}, {16'd0, a});
            checkOutput("bus2", {16'd0, bus2}, {16'd0, b});
        end
        checkOutput("resp_result", {16'd0, resp_result}, {16'd0, expRes});
        checkOutput("resp_err", {31'd0, resp_err}, {31'd0, expErr});
        checkOutput("resp_zero", {31'd0, resp_zero}, {31'd0, (expRes == 16'd0)});
        for (int d = 0; d < respDelay; d++) begin
            @(negedge clk);
            checkOutput("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
            checkOutput("bp_result", {16'd0, resp_result}, {16'd0, expRes});
            checkOutput("bp_err", {31'd0, resp_err}, {31'd0, expErr});
            checkOutput("bp_zero", {31'd0, resp_zero}, {31'd0, (expRes == 16'd0)});
            checkOutput("bp_req_ready", {31'd0, req_ready}, 32'd0);
            checkOutput("bp_strobes", {23'd0, strobeVec}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);
        checkOutput("post_resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("post_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("post_err", {31'd0, resp_err}, 32'd0);
        checkOutput("held_bus1", {16'd0, bus1}, {16'd0, a});
    endtask

    typedef struct {
        logic [3:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        int               respDelay;
        logic [WIDTH-1:0] expRes;
        logic             expErr;
    } vec_t;

    vec_t vecs[12];

    // Hard stop if the run ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0]       rOp;
        logic [WIDTH-1:0] rA;
        logic [WIDTH-1:0] rB;

        vecs[0]  = '{4'd1,  16'd3,     16'd2,     0, 16'd5,     1'b0};
        vecs[1]  = '{4'd2,  16'd3,     16'd2,     0, 16'd1,     1'b0};
        vecs[2]  = '{4'd0,  16'd3,     16'd0,     0, 16'd3,     1'b0};
        vecs[3]  = '{4'd5,  16'h00F0,  16'h0F00,  5, 16'd0,     1'b0};
        vecs[4]  = '{4'd12, 16'h1234,  16'h5678,  1, 16'd0,     1'b1};
        vecs[5]  = '{4'd1,  16'd3,     16'd2,     0, 16'd5,     1'b0};
        vecs[6]  = '{4'd1,  16'hFFFF,  16'h0001,  0, 16'h0000,  1'b0};
        vecs[7]  = '{4'd8,  16'h0001,  16'h0000,  2, 16'hFFFF,  1'b0};
        vecs[8]  = '{4'd3,  16'h8000,  16'h0000,  0, 16'h4000,  1'b0};
        vecs[9]  = '{4'd4,  16'h8000,  16'h0000,  0, 16'h0000,  1'b0};
        vecs[10] = '{4'd6,  16'h00F0,  16'h0F00,  0, 16'h0FF0,  1'b0};
        vecs[11] = '{4'd7,  16'hFF00,  16'h0FF0,  0, 16'hF0F0,  1'b0};

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 4'd0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd0);
        checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("rst_result", {16'd0, resp_result}, 32'd0);
        checkOutput("rst_err", {31'd0, resp_err}, 32'd0);
        checkOutput("rst_zero", {31'd0, resp_zero}, 32'd1);
        checkOutput("rst_bus1", {16'd0, bus1}, 32'd0);
        checkOutput("rst_bus2", {16'd0, bus2}, 32'd0);
        checkOutput("rst_strobes", {23'd0, strobeVec}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_req_ready", {31'd0, req_ready}, 32'd1);

        // Directed table, applied back to back
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].respDelay,
                          vecs[i].expRes, vecs[i].expErr);
        end

        // Reset during the second EXEC cycle of a shl
        req_valid = 1'b1;
        req_op    = 4'd4;
        req_a     = 16'h0003;
        req_b     = 16'h0000;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("mid_shl_c1", {31'd0, shl}, 32'd1);
        @(negedge clk);
        checkOutput("mid_shl_c2", {31'd0, shl}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_shl", {31'd0, shl}, 32'd0);
        checkOutput("mid_rst_strobes", {23'd0, strobeVec}, 32'd0);
        checkOutput("mid_rst_req_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("mid_post_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("mid_post_resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("mid_post_strobes", {23'd0, strobeVec}, 32'd0);
        applyStimulus(4'd1, 16'd3, 16'd2, 0, 16'd5, 1'b0);

        // Randomized transactions against the reference model
        for (int i = 0; i < 40; i++) begin
            rOp = 4'($urandom_range(0, 15));
            rA  = 16'($urandom);
            rB  = 16'($urandom);
            applyStimulus(rOp, rA, rB, int'($urandom_range(0, 2)),
                          refResult(rOp, rA, rB), (rOp > 4'd8));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
